// File: rtl/music_pkg.sv
// Shared types and constants for the pinball music sequencer.
// Optional feature macro: MUSIC_SFX_EN adds the sound-effect state.
package music_pkg;

    // Five-bit note code understood by the tone generator
    typedef logic [4:0] note_t;

    // Mode code supplied by the game controller
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_WAIT = 2'd0;
    localparam mode_t MODE_PLAY = 2'd1;
    localparam mode_t MODE_OVER = 2'd2;
    localparam mode_t MODE_MUTE = 2'd3;

    // Note codes; S is silence
    localparam note_t S  = 5'd0;
    localparam note_t C4 = 5'd1;
    localparam note_t D4 = 5'd2;
    localparam note_t E4 = 5'd3;
    localparam note_t F4 = 5'd4;
    localparam note_t G4 = 5'd5;
    localparam note_t A4 = 5'd6;
    localparam note_t B4 = 5'd7;
    localparam note_t C5 = 5'd8;
    localparam note_t D5 = 5'd9;
    localparam note_t E5 = 5'd10;
    localparam note_t F5 = 5'd11;
    localparam note_t G5 = 5'd12;
    localparam note_t A5 = 5'd13;
    localparam note_t B5 = 5'd14;

    // Sequencer states; the effect state exists only when effects are built in
`ifdef MUSIC_SFX_EN
    typedef enum logic [1:0] {
        ST_MUTE = 2'd0,
        ST_BGM  = 2'd1,
        ST_SFX  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_MUTE = 2'd0,
        ST_BGM  = 2'd1
    } state_t;
`endif

    // Pick the background tune note that matches the current mode
    function automatic note_t pick_bgm_note(mode_t m, note_t w, note_t p, note_t o);
        case (m)
            MODE_WAIT: return w;
            MODE_PLAY: return p;
            MODE_OVER: return o;
            default:   return S;
        endcase
    endfunction

endpackage

// File: rtl/music_sequencer_if.sv
// Bundle between the game/lookup side and the music sequencer.
// The master side supplies mode, trigger and lookup notes; the slave side
// (the sequencer) returns the beat index, tick, busy flag and selected note.
interface music_sequencer_if;
    import music_pkg::*;

    mode_t      mode;
    logic       sfx_req;
    note_t      note_wait;
    note_t      note_play;
    note_t      note_over;
    note_t      note_sfx;
    logic [7:0] beat_cnt;
    logic       beat_tick;
    logic       sfx_busy;
    note_t      note;

    modport master (
        output mode, sfx_req, note_wait, note_play, note_over, note_sfx,
        input  beat_cnt, beat_tick, sfx_busy, note
    );

    modport slave (
        input  mode, sfx_req, note_wait, note_play, note_over, note_sfx,
        output beat_cnt, beat_tick, sfx_busy, note
    );

endinterface

// File: rtl/music_sequencer_beat_prescaler.sv
// Free-running beat prescaler: counts 0..P-1 and flags the last count.
// clr restarts the count so a new tune or effect begins on a full beat.
module beat_prescaler #(
    parameter int P = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (P > 1) ? $clog2(P) : 1;
    localparam logic [W-1:0] LAST = W'(P - 1);

    logic [W-1:0] count;

    // Advance the count, wrapping after LAST; reset and clr both restart it
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/music_sequencer.sv
// Tempo/sequence controller for the pinball audio path.
// Produces the beat index for the tune lookups and registers the note that
// reaches the tone generator. Define MUSIC_SFX_EN to build in the one-shot
// sound effect that preempts the background tune and then resumes it.
module music_sequencer
    import music_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BEAT_HZ = 8,
    parameter int BGM_LEN = 128,
    parameter int SFX_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    music_sequencer_if.slave bus
);

    localparam int P = CLK_HZ / BEAT_HZ;
    localparam logic [7:0] BGM_LAST = 8'(BGM_LEN - 1);

    if (BEAT_HZ < 1 || P < 1) begin : g_tempo_check
        $error("music_sequencer: CLK_HZ/BEAT_HZ must be at least 1");
    end
    if (BGM_LEN < 1 || BGM_LEN > 256) begin : g_bgm_len_check
        $error("music_sequencer: BGM_LEN must be within 1..256");
    end
    if (SFX_LEN < 1 || SFX_LEN > 256) begin : g_sfx_len_check
        $error("music_sequencer: SFX_LEN must be within 1..256");
    end

    state_t     state;
    state_t     next_state;
    mode_t      mode_q;
    logic [7:0] beat_cnt;
    logic [7:0] beat_next;
    note_t      note_q;
    note_t      note_next;
    logic       clr;
    logic       tick;
    logic       mode_chg;
    logic       busy;

`ifdef MUSIC_SFX_EN
    localparam logic [7:0] SFX_LAST = 8'(SFX_LEN - 1);
    logic [7:0] saved_beat;
    logic [7:0] saved_next;
    logic       sfx_last;
    assign sfx_last = tick && (beat_cnt == SFX_LAST);
`else
    logic unused_sfx;
    assign unused_sfx = ^{bus.sfx_req, bus.note_sfx};
`endif

    assign mode_chg = (bus.mode != mode_q);

    beat_prescaler #(.P(P)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_MUTE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: a trigger always grabs the output, an effect hands back at its last beat
    always_comb begin
        next_state = state;
        case (state)
            ST_MUTE: begin
`ifdef MUSIC_SFX_EN
                if (bus.sfx_req) begin
                    next_state = ST_SFX;
                end else
`endif
                if (bus.mode != MODE_MUTE) begin
                    next_state = ST_BGM;
                end
            end
            ST_BGM: begin
`ifdef MUSIC_SFX_EN
                if (bus.sfx_req) begin
                    next_state = ST_SFX;
                end else
`endif
                if (bus.mode == MODE_MUTE) begin
                    next_state = ST_MUTE;
                end
            end
`ifdef MUSIC_SFX_EN
            ST_SFX: begin
                if (!bus.sfx_req && sfx_last) begin
                    next_state = (bus.mode == MODE_MUTE) ? ST_MUTE : ST_BGM;
                end
            end
`endif
            default: next_state = ST_MUTE;
        endcase
    end

    // Outputs: beat index update, prescaler restart, saved beat and note selection
    always_comb begin
        beat_next = beat_cnt;
        clr       = mode_chg;
        note_next = S;
        busy      = 1'b0;
`ifdef MUSIC_SFX_EN
        saved_next = saved_beat;
`endif
        case (state)
            ST_MUTE: begin
                beat_next = 8'd0;
                note_next = S;
`ifdef MUSIC_SFX_EN
                if (bus.sfx_req) begin
                    saved_next = 8'd0;
                    clr        = 1'b1;
                end
`endif
            end
            ST_BGM: begin
                note_next = pick_bgm_note(mode_q, bus.note_wait, bus.note_play, bus.note_over);
`ifdef MUSIC_SFX_EN
                if (bus.sfx_req) begin
                    saved_next = mode_chg ? 8'd0 : beat_cnt;
                    beat_next  = 8'd0;
                    clr        = 1'b1;
                end else
`endif
                if (mode_chg) begin
                    beat_next = 8'd0;
                end else if (tick) begin
                    beat_next = (beat_cnt == BGM_LAST) ? 8'd0 : beat_cnt + 8'd1;
                end
            end
`ifdef MUSIC_SFX_EN
            ST_SFX: begin
                busy      = 1'b1;
                note_next = bus.note_sfx;
                clr       = bus.sfx_req;
                if (mode_chg) begin
                    saved_next = 8'd0;
                end
                if (bus.sfx_req) begin
                    beat_next = 8'd0;
                end else if (sfx_last) begin
                    beat_next = (bus.mode == MODE_MUTE || mode_chg) ? 8'd0 : saved_beat;
                end else if (tick) begin
                    beat_next = beat_cnt + 8'd1;
                end
            end
`endif
            default: begin
                beat_next = 8'd0;
            end
        endcase
    end

    // Datapath registers: registered mode, beat index, saved beat and output note
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_MUTE;
            beat_cnt <= 8'd0;
            note_q   <= S;
`ifdef MUSIC_SFX_EN
            saved_beat <= 8'd0;
`endif
        end else begin
            mode_q   <= bus.mode;
            beat_cnt <= beat_next;
            note_q   <= note_next;
`ifdef MUSIC_SFX_EN
            saved_beat <= saved_next;
`endif
        end
    end

    assign bus.beat_cnt  = beat_cnt;
    assign bus.beat_tick = tick;
    assign bus.sfx_busy  = busy;
    assign bus.note      = note_q;

endmodule
